// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive field sequencer.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DST_MAC,
        SRC_MAC,
        ETHER_TYPE,
        PAYLOAD,
        DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int unsigned MAX_PREAMBLE    = 7;
    localparam int unsigned MAC_LEN         = 6;
    localparam int unsigned ETHERTYPE_LEN   = 2;
    localparam int unsigned MIN_PAYLOAD_CRC = 50;
    localparam int unsigned MAX_PAYLOAD_CRC = 1504;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LEN_W  = 11;

    typedef struct packed {
        logic preamble_or_sfd;
        logic dst_mac;
        logic src_mac;
        logic ether_type;
        logic payload_or_crc;
    } eth_flags_t;

    // Field a byte belongs to, given the state in which it is accepted.
    function automatic eth_flags_t field_flags(state_t s);
        eth_flags_t f;
        f = '0;
        case (s)
            IDLE, PREAMBLE: f.preamble_or_sfd = 1'b1;
            DST_MAC:        f.dst_mac         = 1'b1;
            SRC_MAC:        f.src_mac         = 1'b1;
            ETHER_TYPE:     f.ether_type      = 1'b1;
            PAYLOAD:        f.payload_or_crc  = 1'b1;
            default:        f                 = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/eth_fields_if.sv
// One-hot field classification that accompanies each output byte.
interface eth_fields_if;
    logic is_preamble_or_sfd;
    logic is_dst_mac;
    logic is_src_mac;
    logic is_ether_type;
    logic is_payload_or_crc;

    modport master (
        output is_preamble_or_sfd, is_dst_mac, is_src_mac, is_ether_type, is_payload_or_crc
    );
    modport slave (
        input  is_preamble_or_sfd, is_dst_mac, is_src_mac, is_ether_type, is_payload_or_crc
    );
endinterface

// File: rtl/eth_field_sequencer.sv
// Walks a GMII receive stream through preamble/header/payload, tagging each
// byte with its field and flagging normal completion, runt/oversize and aborts.
module eth_field_sequencer
    import eth_rx_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_valid,
    input  logic                rx_err,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    eth_fields_if.master        fields,
    output logic [IDX_W-1:0]    field_idx,
    output logic                frame_end,
    output logic                frame_runt,
    output logic                frame_oversize,
    output logic                frame_err
);

    state_t           state;
    logic [IDX_W-1:0] pre_cnt;
    logic [IDX_W-1:0] fld_cnt;
    logic [LEN_W-1:0] len_cnt;
    eth_flags_t       flags_q;

    logic             emit_c;
    logic [IDX_W-1:0] idx_c;
    logic [IDX_W-1:0] field_last_c;

    // Decide whether the incoming byte is forwarded, and its index in the field.
    always_comb begin
        emit_c       = 1'b0;
        idx_c        = '0;
        field_last_c = (state == ETHER_TYPE) ? IDX_W'(ETHERTYPE_LEN - 1) : IDX_W'(MAC_LEN - 1);
        case (state)
            IDLE: emit_c = rx_valid && (rx_data == PREAMBLE_BYTE);
            PREAMBLE: begin
                emit_c = rx_valid && !rx_err &&
                         (((rx_data == PREAMBLE_BYTE) && (pre_cnt < IDX_W'(MAX_PREAMBLE))) ||
                          (rx_data == SFD_BYTE));
                idx_c  = pre_cnt;
            end
            DST_MAC, SRC_MAC, ETHER_TYPE: begin
                emit_c = rx_valid && !rx_err;
                idx_c  = fld_cnt;
            end
            PAYLOAD: emit_c = rx_valid && !rx_err;
            default: emit_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pre_cnt        <= '0;
            fld_cnt        <= '0;
            len_cnt        <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            flags_q        <= '0;
            field_idx      <= '0;
            frame_end      <= 1'b0;
            frame_runt     <= 1'b0;
            frame_oversize <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            out_valid      <= emit_c;
            out_data       <= emit_c ? rx_data : '0;
            flags_q        <= emit_c ? field_flags(state) : '0;
            field_idx      <= emit_c ? idx_c : '0;
            frame_end      <= 1'b0;
            frame_runt     <= 1'b0;
            frame_oversize <= 1'b0;
            frame_err      <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == PREAMBLE_BYTE) begin
                            state   <= PREAMBLE;
                            pre_cnt <= IDX_W'(1);
                        end else begin
                            state     <= DROP;
                            frame_err <= 1'b1;
                        end
                    end
                end
                // Dropping rx_valid here is a false carrier, not an abort.
                PREAMBLE: begin
                    if (!rx_valid) begin
                        state <= IDLE;
                    end else if (rx_err) begin
                        state     <= DROP;
                        frame_err <= 1'b1;
                    end else if ((rx_data == PREAMBLE_BYTE) && (pre_cnt < IDX_W'(MAX_PREAMBLE))) begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end else if (rx_data == SFD_BYTE) begin
                        state   <= DST_MAC;
                        fld_cnt <= '0;
                    end else begin
                        state     <= DROP;
                        frame_err <= 1'b1;
                    end
                end
                DST_MAC, SRC_MAC, ETHER_TYPE: begin
                    if (!rx_valid) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (rx_err) begin
                        state     <= DROP;
                        frame_err <= 1'b1;
                    end else if (fld_cnt == field_last_c) begin
                        fld_cnt <= '0;
                        len_cnt <= '0;
                        state   <= (state == DST_MAC) ? SRC_MAC :
                                   (state == SRC_MAC) ? ETHER_TYPE : PAYLOAD;
                    end else begin
                        fld_cnt <= fld_cnt + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (!rx_valid) begin
                        state          <= IDLE;
                        frame_end      <= 1'b1;
                        frame_runt     <= (len_cnt < LEN_W'(MIN_PAYLOAD_CRC));
                        frame_oversize <= (len_cnt > LEN_W'(MAX_PAYLOAD_CRC));
                    end else if (rx_err) begin
                        state     <= DROP;
                        frame_err <= 1'b1;
                    end else if (len_cnt != '1) begin
                        len_cnt <= len_cnt + 1'b1;
                    end
                end
                DROP: begin
                    if (!rx_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fields.is_preamble_or_sfd = flags_q.preamble_or_sfd;
    assign fields.is_dst_mac         = flags_q.dst_mac;
    assign fields.is_src_mac         = flags_q.src_mac;
    assign fields.is_ether_type      = flags_q.ether_type;
    assign fields.is_payload_or_crc  = flags_q.payload_or_crc;

endmodule

// File: tb/tb_eth_field_sequencer.sv
// Directed bench for eth_field_sequencer: expected beats and frame events are
// queued as stimulus is driven and checked as the DUT emits them.
module tb_eth_field_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] field_idx;
    logic       frame_end;
    logic       frame_runt;
    logic       frame_oversize;
    logic       frame_err;

    eth_fields_if fi ();

    eth_field_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_err         (rx_err),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .fields         (fi),
        .field_idx      (field_idx),
        .frame_end      (frame_end),
        .frame_runt     (frame_runt),
        .frame_oversize (frame_oversize),
        .frame_err      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] F_PRE = 5'b10000;
    localparam logic [4:0] F_DST = 5'b01000;
    localparam logic [4:0] F_SRC = 5'b00100;
    localparam logic [4:0] F_ET  = 5'b00010;
    localparam logic [4:0] F_PAY = 5'b00001;

    // Event word: {frame_end, frame_err, frame_runt, frame_oversize}
    localparam logic [3:0] EV_END  = 4'b1000;
    localparam logic [3:0] EV_RUNT = 4'b1010;
    localparam logic [3:0] EV_OVER = 4'b1001;
    localparam logic [3:0] EV_ERR  = 4'b0100;

    logic [15:0] beat_q[$];
    logic [3:0]  ev_q[$];
    logic [15:0] exp_beat;
    logic [3:0]  exp_ev;
    int          n_cmp = 0;
    int          n_err = 0;

    wire [4:0] flags = {fi.is_preamble_or_sfd, fi.is_dst_mac, fi.is_src_mac,
                        fi.is_ether_type, fi.is_payload_or_crc};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e);
        rx_valid = v;
        rx_data  = d;
        rx_err   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic good(input logic [7:0] d, input logic [4:0] f, input logic [2:0] i);
        beat_q.push_back({d, f, i});
        drive(1'b1, d, 1'b0);
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_pre(input int npre);
        for (int i = 0; i < npre; i++) good(8'h55, F_PRE, 3'(i));
    endtask

    task automatic send_sfd_macs(input int npre, input int nsrc);
        good(8'hD5, F_PRE, (npre > 7) ? 3'd7 : 3'(npre));
        for (int i = 0; i < 6; i++) good(8'(8'hA0 + i), F_DST, 3'(i));
        for (int i = 0; i < nsrc; i++) good(8'(8'hB0 + i), F_SRC, 3'(i));
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) good(8'($urandom), F_PAY, 3'd0);
    endtask

    task automatic send_frame(input int npre, input int npay, input logic [3:0] ev);
        send_pre(npre);
        send_sfd_macs(npre, 6);
        good(8'h08, F_ET, 3'd0);
        good(8'h00, F_ET, 3'd1);
        send_payload(npay);
        ev_q.push_back(ev);
        gap(1);
    endtask

    // Output monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("beat_expected", 32'(beat_q.size() != 0), 32'(1));
                if (beat_q.size() != 0) begin
                    exp_beat = beat_q.pop_front();
                    chk("beat", 32'({out_data, flags, field_idx}), 32'(exp_beat));
                end
            end else begin
                chk("flags_idle", 32'(flags), 32'(0));
            end
            if (frame_end || frame_err) begin
                chk("end_err_exclusive", 32'(frame_end & frame_err), 32'(0));
                chk("event_expected", 32'(ev_q.size() != 0), 32'(1));
                if (ev_q.size() != 0) begin
                    exp_ev = ev_q.pop_front();
                    chk("event", 32'({frame_end, frame_err, frame_runt, frame_oversize}), 32'(exp_ev));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({out_valid, out_data, flags, field_idx,
                                  frame_end, frame_err, frame_runt, frame_oversize}), 32'(0));
        rst_n = 1'b1;
        gap(2);

        // Nominal frame, then a back-to-back runt frame after one idle cycle
        send_frame(7, 60, EV_END);
        send_frame(7, 20, EV_RUNT);

        // rx_valid drops after the third source MAC byte, then a clean frame
        send_pre(7);
        send_sfd_macs(7, 3);
        ev_q.push_back(EV_ERR);
        gap(1);
        send_frame(7, 50, EV_END);
        send_frame(3, 49, EV_RUNT);

        // Eight preamble bytes: the eighth aborts, the rest is dropped silently
        send_pre(7);
        ev_q.push_back(EV_ERR);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        gap(1);
        send_frame(1, 46, EV_RUNT);

        // rx_err on the tenth payload byte
        send_pre(7);
        send_sfd_macs(7, 6);
        good(8'h08, F_ET, 3'd0);
        good(8'h00, F_ET, 3'd1);
        send_payload(9);
        ev_q.push_back(EV_ERR);
        drive(1'b1, 8'h3C, 1'b1);
        repeat (5) drive(1'b1, 8'($urandom), 1'b0);
        gap(1);

        // SFD with no preamble, then a false carrier
        ev_q.push_back(EV_ERR);
        drive(1'b1, 8'hD5, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        gap(1);
        send_pre(3);
        gap(1);

        // Oversize boundary
        send_frame(7, 1504, EV_END);
        send_frame(7, 1505, EV_OVER);

        // Asynchronous reset while in ETHER_TYPE
        send_pre(7);
        send_sfd_macs(7, 6);
        good(8'h08, F_ET, 3'd0);
        rx_data = 8'h00;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", 32'({out_valid, out_data, flags, field_idx,
                                           frame_end, frame_err, frame_runt, frame_oversize}), 32'(0));
        rx_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap(1);
        send_frame(7, 60, EV_END);

        gap(4);
        chk("beats_drained", 32'(beat_q.size()), 32'(0));
        chk("events_drained", 32'(ev_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
